// File: rtl/instr_fetch_seq_if.sv
// rtl/instr_fetch_seq_if.sv - fetch stage bus bundle: imem request/response and decode handshake
interface instr_fetch_seq_if #(
  parameter int ADDR_W = 8
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_rdata;
  logic              imem_valid;
  logic              instr_valid;
  logic [15:0]       instr;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] instr_pc;
  logic              dec_ready;
  logic              skip_cond;
  logic              halted;

  // Fetch sequencer side
  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, instr_pc, halted,
    input  imem_rdata, imem_valid, dec_ready, skip_cond
  );

  // Memory / decoder side
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, instr_pc, halted,
    output imem_rdata, imem_valid, dec_ready, skip_cond
  );
endinterface

// File: rtl/instr_fetch_seq.sv
// rtl/instr_fetch_seq.sv - program counter, single-outstanding instruction fetch and decode hand-off
module instr_fetch_seq #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_seq_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_HALT = 4'd1;
  localparam logic [3:0] OP_SKIP = 4'd5;
  localparam logic [3:0] OP_JUMP = 4'd6;

  // Jump targets come from the 12-bit immediate; wider PCs zero-extend it.
  localparam int JW = (ADDR_W > 12) ? 12 : ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] jump_tgt;

  assign jump_tgt = ADDR_W'(instr_q[JW-1:0]);

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Next state and next PC; memory responses outside WAIT are dropped
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.imem_valid) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = pc_q;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.dec_ready) begin
          case (instr_q[15:12])
            OP_HALT: begin
              state_d = S_HALT;
            end
            OP_JUMP: begin
              pc_d    = jump_tgt;
              state_d = S_FETCH;
            end
            OP_SKIP: begin
              pc_d    = bus.skip_cond ? (pc_q + ADDR_W'(2)) : (pc_q + ADDR_W'(1));
              state_d = S_FETCH;
            end
            default: begin
              pc_d    = pc_q + ADDR_W'(1);
              state_d = S_FETCH;
            end
          endcase
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state or driven straight from registers
  always_comb begin
    bus.imem_req    = (state_q == S_FETCH);
    bus.imem_addr   = pc_q;
    bus.instr_valid = (state_q == S_ISSUE);
    bus.instr       = instr_q;
    bus.opcode      = instr_q[15:12];
    bus.instr_pc    = instr_pc_q;
    bus.halted      = (state_q == S_HALT);
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb/tb_instr_fetch_seq.sv - self-checking bench for instr_fetch_seq
module tb_instr_fetch_seq;
  localparam int            AW  = 8;
  localparam logic [AW-1:0] RPC = 8'h00;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_seq_if #(.ADDR_W(AW)) bus ();
  instr_fetch_seq #(.ADDR_W(AW), .RESET_PC(RPC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [15:0] mem [256];
  int lat_fix  = 1;   // 0 selects a random latency of 1..3 cycles
  bit spurious = 1'b0;
  int total    = 0;
  int bad      = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory: captures the word at request time, answers after the latency
  initial begin : responder
    logic [15:0] data;
    int          l;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (bus.imem_req === 1'b1) begin
        data = mem[bus.imem_addr];
        l    = (lat_fix == 0) ? int'($urandom_range(1, 3)) : lat_fix;
        bus.imem_valid = 1'b0;
        repeat (l) @(posedge clk);
        #1;
        bus.imem_valid = 1'b1;
        bus.imem_rdata = data;
        @(posedge clk);
        #1;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 16'($urandom);
      end else if (spurious) begin
        bus.imem_valid = 1'($urandom_range(0, 1));
        bus.imem_rdata = 16'($urandom);
      end else begin
        bus.imem_valid = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Reference next-PC computed from the opcode rules with plain modular arithmetic
  function automatic int model_next(int pc, logic [15:0] ins, logic cond);
    int nxt;
    case (int'(ins[15:12]))
      1:       nxt = pc;
      6:       nxt = int'(ins[11:0]) % (1 << AW);
      5:       nxt = (pc + (cond ? 2 : 1)) % (1 << AW);
      default: nxt = (pc + 1) % (1 << AW);
    endcase
    return nxt;
  endfunction

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(output logic [AW-1:0] addr, output bit ok);
    ok   = 1'b0;
    addr = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.imem_req === 1'b1) begin
        addr = bus.imem_addr;
        ok   = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ivalid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bus.dec_ready = 1'b0;
    bus.skip_cond = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.imem_req, bus.instr_valid, bus.halted} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=000", {bus.imem_req, bus.instr_valid, bus.halted});
    end
    total++;
    if (bus.opcode !== 4'h0 || bus.instr !== 16'h0) begin
      bad++; $display("FAIL reset_instr got=%h/%h exp=0/0000", bus.opcode, bus.instr);
    end
    total++;
    if (bus.imem_addr !== RPC || bus.instr_pc !== RPC) begin
      bad++; $display("FAIL reset_pc got=%h/%h exp=%h", bus.imem_addr, bus.instr_pc, RPC);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential;
    logic [AW-1:0] a;
    bit ok;
    int rc, vc;
    mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'h0000;
    lat_fix = 1; bus.dec_ready = 1'b1;
    do_reset(4);
    for (int k = 0; k < 2; k++) begin
      wait_req(a, ok);
      rc = cyc;
      total++;
      if (!ok || a !== AW'(k)) begin
        bad++; $display("FAIL seq_req%0d got=%h ok=%0d exp=%h", k, a, ok, AW'(k));
      end
      if (k == 1) begin
        total++;
        if (rc - vc !== 1) begin
          bad++; $display("FAIL seq_refetch_gap got=%0d exp=1", rc - vc);
        end
      end
      wait_ivalid(ok);
      vc = cyc;
      total++;
      if (!ok || vc - rc !== 2) begin
        bad++; $display("FAIL seq_latency%0d got=%0d exp=2", k, vc - rc);
      end
      total++;
      if (bus.instr_pc !== AW'(k) || bus.opcode !== 4'h0) begin
        bad++; $display("FAIL seq_present%0d got=%h/%h exp=%h/0", k, bus.instr_pc, bus.opcode, AW'(k));
      end
    end
  endtask

  task automatic test_jump_skip;
    logic [AW-1:0] a;
    bit ok;
    logic [AW-1:0] exp_a [9];
    exp_a = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h25, 8'h10, 8'h12, 8'h10, 8'h11};
    mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'h0000; mem[3] = 16'h6025;
    mem[8'h25] = 16'h6010; mem[8'h10] = 16'h5000; mem[8'h12] = 16'h6010; mem[8'h11] = 16'h0000;
    lat_fix = 0; bus.dec_ready = 1'b1; bus.skip_cond = 1'b1;
    do_reset(4);
    for (int i = 0; i < 9; i++) begin
      wait_req(a, ok);
      total++;
      if (!ok || a !== exp_a[i]) begin
        bad++; $display("FAIL jump_skip_addr%0d got=%h exp=%h", i, a, exp_a[i]);
      end
      if (i == 6) bus.skip_cond = 1'b0;
    end
  endtask

  task automatic test_hold;
    logic [AW-1:0] a;
    bit ok;
    mem[0] = 16'h2abc; mem[1] = 16'h0000;
    lat_fix = 0; bus.dec_ready = 1'b0;
    do_reset(4);
    wait_ivalid(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL hold_first_valid got=0 exp=1");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({bus.instr_valid, bus.instr, bus.opcode, bus.instr_pc, bus.imem_req} !== {1'b1, 16'h2abc, 4'h2, 8'h00, 1'b0}) begin
        bad++; $display("FAIL hold_stable%0d got=%b/%h/%h/%h/%b exp=1/2abc/2/00/0", i,
                        bus.instr_valid, bus.instr, bus.opcode, bus.instr_pc, bus.imem_req);
      end
    end
    bus.dec_ready = 1'b1;
    @(negedge clk);
    bus.dec_ready = 1'b0;
    total++;
    if ({bus.instr_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 8'h01}) begin
      bad++; $display("FAIL hold_accept got=%b/%b/%h exp=0/1/01", bus.instr_valid, bus.imem_req, bus.imem_addr);
    end
    wait_ivalid(ok);
    total++;
    if (!ok || bus.instr_pc !== 8'h01) begin
      bad++; $display("FAIL hold_next_pc got=%h exp=01", bus.instr_pc);
    end
  endtask

  task automatic test_halt;
    logic [AW-1:0] a;
    bit ok;
    mem[0] = 16'h1000;
    lat_fix = 0; bus.dec_ready = 1'b1;
    do_reset(4);
    wait_ivalid(ok);
    total++;
    if (!ok || bus.halted !== 1'b0 || bus.opcode !== 4'h1) begin
      bad++; $display("FAIL halt_present got=%b/%h exp=0/1", bus.halted, bus.opcode);
    end
    @(negedge clk);
    total++;
    if (bus.halted !== 1'b1 || bus.instr_valid !== 1'b0) begin
      bad++; $display("FAIL halt_enter got=%b/%b exp=1/0", bus.halted, bus.instr_valid);
    end
    spurious = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if ({bus.imem_req, bus.instr_valid, bus.halted} !== 3'b001) begin
        bad++; $display("FAIL halt_sticky%0d got=%b exp=001", i, {bus.imem_req, bus.instr_valid, bus.halted});
      end
    end
    spurious = 1'b0;
    mem[0] = 16'h0000;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (bus.halted !== 1'b0) begin
      bad++; $display("FAIL halt_reset got=%b exp=0", bus.halted);
    end
    rst_n = 1'b1;
    wait_req(a, ok);
    total++;
    if (!ok || a !== RPC) begin
      bad++; $display("FAIL halt_restart got=%h exp=%h", a, RPC);
    end
  endtask

  task automatic test_reset_in_wait;
    logic [AW-1:0] a;
    bit ok;
    mem[0] = 16'h4ccc;
    lat_fix = 2; bus.dec_ready = 1'b1;
    do_reset(4);
    wait_req(a, ok);
    total++;
    if (!ok || a !== RPC) begin
      bad++; $display("FAIL rwait_first_req got=%h exp=%h", a, RPC);
    end
    @(negedge clk);
    rst_n = 1'b0;
    mem[0] = 16'h0123;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      bad++; $display("FAIL rwait_idle got=%b/%b exp=0/0", bus.instr_valid, bus.imem_req);
    end
    @(negedge clk);
    total++;
    if ({bus.instr_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, RPC}) begin
      bad++; $display("FAIL rwait_refetch got=%b/%b/%h exp=0/1/%h", bus.instr_valid, bus.imem_req, bus.imem_addr, RPC);
    end
    wait_ivalid(ok);
    total++;
    if (!ok || bus.instr !== 16'h0123 || bus.instr_pc !== RPC) begin
      bad++; $display("FAIL rwait_instr got=%h@%h exp=0123@%h", bus.instr, bus.instr_pc, RPC);
    end
  endtask

  task automatic test_wrap;
    logic [AW-1:0] a;
    bit ok;
    logic [AW-1:0] exp_a [7];
    exp_a = '{8'h00, 8'hff, 8'h00, 8'hfe, 8'h00, 8'hff, 8'h01};
    mem[0] = 16'h60ff; mem[8'hff] = 16'h7000; mem[8'hfe] = 16'h5000; mem[1] = 16'h0000;
    lat_fix = 0; bus.dec_ready = 1'b1; bus.skip_cond = 1'b1;
    do_reset(4);
    for (int i = 0; i < 7; i++) begin
      wait_req(a, ok);
      total++;
      if (!ok || a !== exp_a[i]) begin
        bad++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, a, exp_a[i]);
      end
      if (i == 1) mem[0] = 16'h60fe;
      if (i == 3) begin
        mem[0]     = 16'h60ff;
        mem[8'hff] = 16'h5000;
      end
    end
  endtask

  task automatic test_random;
    int m_pc;
    int n_acc;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i][15:12] == 4'h1) mem[i][15:12] = 4'h0;
    end
    lat_fix = 0; bus.dec_ready = 1'b0; bus.skip_cond = 1'b0;
    do_reset(4);
    m_pc  = int'(RPC);
    n_acc = 0;
    for (int c = 0; c < 3000 && n_acc < 60; c++) begin
      @(negedge clk);
      if (bus.imem_req === 1'b1) begin
        total++;
        if (bus.imem_addr !== AW'(m_pc)) begin
          bad++; $display("FAIL rnd_addr got=%h exp=%h", bus.imem_addr, AW'(m_pc));
        end
      end
      if (bus.instr_valid === 1'b1) begin
        total++;
        if (bus.instr_pc !== AW'(m_pc) || bus.instr !== mem[m_pc] || bus.opcode !== mem[m_pc][15:12]) begin
          bad++; $display("FAIL rnd_instr got=%h@%h exp=%h@%h", bus.instr, bus.instr_pc, mem[m_pc], AW'(m_pc));
        end
      end
      bus.dec_ready = 1'($urandom_range(0, 1));
      bus.skip_cond = 1'($urandom_range(0, 1));
      if (bus.instr_valid === 1'b1 && bus.dec_ready) begin
        m_pc = model_next(m_pc, mem[m_pc], bus.skip_cond);
        n_acc++;
      end
    end
    total++;
    if (n_acc != 60) begin
      bad++; $display("FAIL rnd_progress got=%0d exp=60", n_acc);
    end
    bus.dec_ready = 1'b0;
  endtask

  initial begin : main
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    bus.dec_ready = 1'b0;
    bus.skip_cond = 1'b0;
    test_reset();
    test_sequential();
    test_jump_skip();
    test_hold();
    test_halt();
    test_reset_in_wait();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Fetch/sequencer stage directly upstream of the opcode decoder (controlunit).
- Owns the program counter, fetches 16-bit instructions from instruction memory over a single-outstanding req/valid handshake, and presents each instruction (opcode in [15:12]) to decode with a valid/ready handshake.
- Resolves next-PC for sequential flow, jump, skip and halt.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width; the PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_req  out  1  one-cycle fetch request.
- imem_addr  out  ADDR_W  fetch address (current PC).
- imem_rdata  in  16  fetched instruction word.
- imem_valid  in  1  imem_rdata valid; arrives at least 1 cycle after imem_req.
- instr_valid  out  1  instruction held for decode.
- instr  out  16  held instruction word.
- opcode  out  4  instr[15:12], drives the decoder.
- instr_pc  out  ADDR_W  address of the held instruction.
- dec_ready  in  1  downstream accepts the held instruction this cycle.
- skip_cond  in  1  skip condition; sampled only when a skip instruction is accepted.
- halted  out  1  core halted; sticky until reset.

Behaviour:
- Opcodes: 0 add, 1 halt, 2 load, 3 store, 4 clear, 5 skip, 6 jump, 7-15 reserved (treated as sequential).
- States: IDLE, FETCH, WAIT, ISSUE, HALT. All outputs are registered or decoded from state.
- Reset (rst_n=0 at an edge):
  - state=IDLE, pc=RESET_PC, instr=0, instr_pc=RESET_PC, halted=0.
  - Outputs: imem_req=0, instr_valid=0, opcode=0, imem_addr=RESET_PC.
  - Applies from any state, including mid-WAIT or mid-ISSUE. A late imem_valid is dropped because it arrives outside WAIT.
- IDLE: advances to FETCH on the next cycle.
- FETCH:
  - imem_req=1 and imem_addr=pc for exactly one cycle.
  - Advances to WAIT.
- WAIT:
  - imem_req=0.
  - On imem_valid: latch instr=imem_rdata and instr_pc=pc, then go to ISSUE.
  - Otherwise stay in WAIT with no timeout.
  - imem_valid in any state other than WAIT is ignored.
- ISSUE:
  - instr_valid=1. instr, opcode and instr_pc are held stable while dec_ready=0.
  - Acceptance occurs when instr_valid and dec_ready are both 1 at an edge. On acceptance, next-PC is:
    - halt (1): pc unchanged; state=HALT; halted=1 from the next cycle.
    - jump (6): pc = instr[ADDR_W-1:0] (for ADDR_W>12, upper bits zero-extended); state=FETCH.
    - skip (5): pc = pc+2 if skip_cond=1, else pc+1; state=FETCH.
    - all others: pc = pc+1; state=FETCH.
  - All additions are modulo 2^ADDR_W (wrap, no carry out). Example: with ADDR_W=8, skip at pc=0xFF gives next pc 0x01.
- HALT:
  - imem_req=0, instr_valid=0, halted=1.
  - Absorbing; only reset exits.
- Timing:
  - Minimum latency from the FETCH cycle to instr_valid=1 is 2 cycles (req at cycle n, imem_valid at n+1, instr_valid at n+2).
  - Peak throughput is 1 instruction per 3 cycles. No prefetch, and never more than one outstanding request.
- Simultaneous events: dec_ready while instr_valid=0 has no effect; skip_cond is ignored except at skip acceptance.

Test Plan:
1. Reset, then imem with 1-cycle latency returning add(0x0000) at addr 0 and 1 -> imem_req pulses at addr 0, then 1; instr_valid high 2 cycles after each req; instr_pc=0 then 1; opcode=0.
2. Jump 0x6025 at pc 3, dec_ready=1 -> next imem_addr=0x25. Skip 0x5000 at pc 0x10 with skip_cond=1 -> next addr 0x12; with skip_cond=0 -> 0x11.
3. Hold dec_ready=0 for 5 cycles with load 0x2xxx presented -> instr, opcode=2 and instr_pc stable; no imem_req. Raise dec_ready -> exactly one accept, then pc+1 fetch.
4. Halt 0x1000 accepted -> halted=1 next cycle; imem_req stays 0 for 20 cycles regardless of imem_valid pulses. Pulse rst_n=0 -> halted=0, fetch resumes at RESET_PC.
5. Assert rst_n=0 during WAIT; memory returns imem_valid 2 cycles later during IDLE -> response ignored, instr_valid stays 0, first post-reset fetch at RESET_PC.
6. ADDR_W=8: sequential instruction at pc 0xFF -> next fetch 0x00; skip taken at 0xFE -> next fetch 0x00.
